// File: rtl/reg_rw_pkg.sv
// Shared definitions for the register read/write controller: op encodings,
// BRAM read latency and the in-flight slot tag carried down the access pipe.
package reg_rw_pkg;

   localparam logic [1:0] OP_READ  = 2'b00;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_ADD   = 2'b10;
   localparam logic [1:0] OP_RSVD  = 2'b11;

   localparam int MEM_RD_LAT = 2;

   // valid: slot occupied; acc: real BRAM access; resp: produces a response;
   // zero: response data forced to 0; add: first half of an atomic add
   typedef struct packed {
      logic valid;
      logic acc;
      logic resp;
      logic zero;
      logic add;
   } slot_t;

endpackage

// File: rtl/reg_rw_resp_fifo.sv
// Response buffer: synchronous FIFO with a registered output stage
// (first-word fall-through) and a total occupancy count.
module reg_rw_resp_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic [CW-1:0]    count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] store [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    buf_count;
   logic             load;
   logic             bypass;
   logic             store_wr;
   logic             store_rd;

   // The output stage reloads when empty or being consumed; a push goes
   // straight to it only if nothing older is waiting in storage.
   assign load     = !out_valid || out_ready;
   assign bypass   = push && load && (buf_count == '0);
   assign store_wr = push && !bypass;
   assign store_rd = load && (buf_count != '0);
   assign count    = buf_count + CW'(out_valid);

   always_ff @(posedge clk) begin
      if (store_wr) store[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         buf_count <= '0;
      end else begin
         if (store_rd) begin
            out_valid <= 1'b1;
            out_data  <= store[rd_ptr];
            rd_ptr    <= rd_ptr + 1'b1;
         end else if (bypass) begin
            out_valid <= 1'b1;
            out_data  <= push_data;
         end else if (load) begin
            out_valid <= 1'b0;
         end
         if (store_wr) wr_ptr <= wr_ptr + 1'b1;
         case ({store_wr, store_rd})
            2'b10:   buf_count <= buf_count + 1'b1;
            2'b01:   buf_count <= buf_count - 1'b1;
            default: buf_count <= buf_count;
         endcase
      end
   end

endmodule

// File: rtl/reg_rw_ctrl.sv
// Register read/write controller in front of a single-port BRAM with a
// 2-cycle registered read. Optional atomic add: define REG_RW_ATOMIC_ADD_EN.
module reg_rw_ctrl
   import reg_rw_pkg::*;
#(
   parameter int L2_DEPTH   = 8,
   parameter int WIDTH      = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [1:0]          req_op,
   input  logic [L2_DEPTH-1:0] req_index,
   input  logic [WIDTH-1:0]    req_data,
   output logic                resp_valid,
   input  logic                resp_ready,
   output logic [WIDTH-1:0]    resp_data,
   output logic                mem_en,
   output logic                mem_we,
   output logic                mem_regce,
   output logic                mem_rst,
   output logic [L2_DEPTH-1:0] mem_addr,
   output logic [WIDTH-1:0]    mem_din,
   input  logic [WIDTH-1:0]    mem_dout
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);

   slot_t            pipe [MEM_RD_LAT];
   slot_t            issue_slot;
   slot_t            last;
   logic             ready_en;
   logic             busy;
   logic             accept;
   logic             credit_ok;
   logic [CW-1:0]    occ;
   logic [CW-1:0]    inflight;
   logic [CW:0]      used;
   logic             push;
   logic [WIDTH-1:0] push_data;

   // Handshakes: a transfer happens on a rising edge where valid and ready
   // are both high; ready never depends on valid, and a valid response holds
   // its data until taken.
   always_comb begin
      inflight = '0;
      for (int i = 0; i < MEM_RD_LAT; i++) inflight = inflight + CW'(pipe[i].valid);
   end

   assign used      = {1'b0, occ} + {1'b0, inflight};
   assign credit_ok = used < (CW + 1)'(FIFO_DEPTH);
   assign req_ready = ready_en && !rst && !busy && credit_ok;
   assign accept    = req_valid && req_ready;
   assign mem_rst   = rst;
   assign mem_regce = pipe[0].valid && pipe[0].acc;
   assign last      = pipe[MEM_RD_LAT-1];
   assign push      = last.valid && last.resp;
   assign push_data = last.zero ? '0 : mem_dout;

`ifdef REG_RW_ATOMIC_ADD_EN
   logic                wb_pending;
   logic [L2_DEPTH-1:0] add_index;
   logic [WIDTH-1:0]    add_operand;
   logic [WIDTH-1:0]    add_sum;

   // The old value arrives on mem_dout at the end of T+2; the sum is written
   // back in T+3 and its write-first echo is tagged as producing no response.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_pending  <= 1'b0;
         add_index   <= '0;
         add_operand <= '0;
         add_sum     <= '0;
      end else begin
         if (accept && req_op == OP_ADD) begin
            add_index   <= req_index;
            add_operand <= req_data;
         end
         wb_pending <= last.valid && last.add;
         if (last.valid && last.add) add_sum <= mem_dout + add_operand;
      end
   end

   always_comb begin
      busy = wb_pending;
      for (int i = 0; i < MEM_RD_LAT; i++) busy = busy | (pipe[i].valid & pipe[i].add);
   end
`else
   assign busy = 1'b0;
`endif

   always_comb begin
      mem_en     = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = req_index;
      mem_din    = req_data;
      issue_slot = '0;
`ifdef REG_RW_ATOMIC_ADD_EN
      if (wb_pending) begin
         mem_en         = 1'b1;
         mem_we         = 1'b1;
         mem_addr       = add_index;
         mem_din        = add_sum;
         issue_slot.valid = 1'b1;
         issue_slot.acc   = 1'b1;
      end else
`endif
      if (accept) begin
         issue_slot.valid = 1'b1;
         issue_slot.resp  = 1'b1;
         case (req_op)
            OP_READ: begin
               mem_en         = 1'b1;
               issue_slot.acc = 1'b1;
            end
            OP_WRITE: begin
               mem_en         = 1'b1;
               mem_we         = 1'b1;
               issue_slot.acc = 1'b1;
            end
`ifdef REG_RW_ATOMIC_ADD_EN
            OP_ADD: begin
               mem_en         = 1'b1;
               issue_slot.acc = 1'b1;
               issue_slot.add = 1'b1;
            end
`endif
            default: issue_slot.zero = 1'b1;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ready_en <= 1'b0;
         for (int i = 0; i < MEM_RD_LAT; i++) pipe[i] <= '0;
      end else begin
         ready_en <= 1'b1;
         pipe[0]  <= issue_slot;
         for (int i = 1; i < MEM_RD_LAT; i++) pipe[i] <= pipe[i-1];
      end
   end

   reg_rw_resp_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (WIDTH),
      .CW    (CW)
   ) u_resp_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_data),
      .out_ready (resp_ready),
      .out_valid (resp_valid),
      .out_data  (resp_data),
      .count     (occ)
   );

endmodule

// File: tb/tb_reg_rw_ctrl.sv
// Bench for reg_rw_ctrl with a write-first 2-cycle BRAM model and a response
// scoreboard; the atomic-add scenario runs when REG_RW_ATOMIC_ADD_EN is set.
module tb_reg_rw_ctrl;
   import reg_rw_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_op;
   logic [7:0]  req_index;
   logic [31:0] req_data;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_data;
   logic        mem_en, mem_we, mem_regce, mem_rst;
   logic [7:0]  mem_addr;
   logic [31:0] mem_din;
   logic [31:0] mem_dout;

   logic [31:0] bram [256];
   logic [31:0] dout_r;
   logic [31:0] model [256];
   logic [31:0] exp_q [$];
   int          n_checks = 0;
   int          n_pass = 0;
   int          stall_cnt = 0;

   always #5 clk = ~clk;

   reg_rw_ctrl #(.L2_DEPTH(8), .WIDTH(32), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_index(req_index), .req_data(req_data),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
      .mem_en(mem_en), .mem_we(mem_we), .mem_regce(mem_regce), .mem_rst(mem_rst),
      .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
   );

   // write-first BRAM with address register and output register
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) begin
            bram[mem_addr] <= mem_din;
            dout_r <= mem_din;
         end else begin
            dout_r <= bram[mem_addr];
         end
      end
      if (mem_rst) mem_dout <= '0;
      else if (mem_regce) mem_dout <= dout_r;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   // scoreboard: expected value computed at acceptance, compared at pop
   always @(negedge clk) begin
      if (!rst) begin
         if (resp_valid && resp_ready) begin
            if (exp_q.size() == 0) check("unexpected_resp", 32'd1, 32'd0);
            else check("resp_data", resp_data, exp_q.pop_front());
         end
         if (req_valid && req_ready) begin
            case (req_op)
               OP_READ: exp_q.push_back(model[req_index]);
               OP_WRITE: begin
                  model[req_index] = req_data;
                  exp_q.push_back(req_data);
               end
`ifdef REG_RW_ATOMIC_ADD_EN
               OP_ADD: begin
                  exp_q.push_back(model[req_index]);
                  model[req_index] = model[req_index] + req_data;
               end
`endif
               default: exp_q.push_back(32'd0);
            endcase
         end
      end
   end

   // called at posedge+#1; returns at posedge+#1 right after acceptance
   task automatic send(input logic [1:0] op, input logic [7:0] idx, input logic [31:0] d);
      int   waited = 0;
      logic exp_en;
      req_valid = 1'b1;
      req_op    = op;
      req_index = idx;
      req_data  = d;
      @(negedge clk);
      while (!req_ready && waited < 200) begin
         resp_ready = 1'b1;
         @(negedge clk);
         waited++;
      end
      if (waited > 0) stall_cnt++;
      if (!req_ready) check("req_timeout", 32'd0, 32'd1);
      exp_en = (op == OP_READ) || (op == OP_WRITE);
`ifdef REG_RW_ATOMIC_ADD_EN
      exp_en = exp_en || (op == OP_ADD);
`endif
      check("issue_mem_en", {31'd0, mem_en}, {31'd0, exp_en});
      check("issue_mem_we", {31'd0, mem_we}, {31'd0, op == OP_WRITE});
      if (exp_en) check("issue_mem_addr", {24'd0, mem_addr}, {24'd0, idx});
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(posedge clk);
         n++;
      end
      check("drain", 32'(exp_q.size()), 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc;
      logic got;
      for (int i = 0; i < 256; i++) begin
         bram[i]  = '0;
         model[i] = '0;
      end
      dout_r = '0;
      rst = 1'b1; req_valid = 1'b0; req_op = OP_READ; req_index = '0; req_data = '0;
      resp_ready = 1'b1;

      // reset state
      repeat (3) @(negedge clk);
      check("rst_req_ready", {31'd0, req_ready}, 32'd0);
      check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      check("rst_resp_data", resp_data, 32'd0);
      check("rst_mem_en", {31'd0, mem_en}, 32'd0);
      check("rst_mem_we", {31'd0, mem_we}, 32'd0);
      check("rst_mem_regce", {31'd0, mem_regce}, 32'd0);
      check("rst_mem_rst", {31'd0, mem_rst}, 32'd1);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("ready_same_cycle_as_release", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
      check("ready_after_release", {31'd0, req_ready}, 32'd1);
      @(posedge clk); #1;

      // write then read index 5, with read latency measured
      send(OP_WRITE, 8'd5, 32'hDEADBEEF);
      drain();
      send(OP_READ, 8'd5, 32'd0);
      check("regce_t1", {31'd0, mem_regce}, 32'd1);
      @(negedge clk);
      check("lat_t1_valid", {31'd0, resp_valid}, 32'd0);
      @(negedge clk);
      check("lat_t2_valid", {31'd0, resp_valid}, 32'd0);
      @(negedge clk);
      check("lat_t3_valid", {31'd0, resp_valid}, 32'd1);
      @(posedge clk); #1;
      drain();
      @(negedge clk);
      check("idle_mem_en", {31'd0, mem_en}, 32'd0);
      check("idle_mem_we", {31'd0, mem_we}, 32'd0);
      @(posedge clk); #1;

      // fill some registers, then back-to-back reads 0..7
      for (int i = 0; i < 8; i++) send(OP_WRITE, 8'(i), 32'h1000_0000 + 32'(i * 7));
      drain();
      stall_cnt = 0;
      for (int i = 0; i < 8; i++) send(OP_READ, 8'(i), 32'd0);
      check("b2b_ready_stalls", 32'(stall_cnt), 32'd0);
      drain();

      // reserved op and (in default build) op 10 return zero without writing
      send(OP_RSVD, 8'd5, 32'h5555_5555);
`ifndef REG_RW_ATOMIC_ADD_EN
      send(OP_ADD, 8'd5, 32'h1);
`endif
      send(OP_READ, 8'd5, 32'd0);
      drain();

      // backpressure: exactly FIFO_DEPTH reads accepted, then drained in order
      resp_ready = 1'b0;
      req_valid  = 1'b1;
      req_op     = OP_READ;
      req_index  = 8'd0;
      acc = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         got = req_ready;
         if (got) acc++;
         @(posedge clk); #1;
         if (got) req_index = req_index + 8'd1;
      end
      check("bp_accepted", 32'(acc), 32'd4);
      check("bp_ready_low", {31'd0, req_ready}, 32'd0);
      check("bp_resp_held", {31'd0, resp_valid}, 32'd1);
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      drain();

`ifdef REG_RW_ATOMIC_ADD_EN
      // atomic add wraps and blocks requests for three cycles
      send(OP_WRITE, 8'd3, 32'hFFFF_FFFF);
      drain();
      send(OP_ADD, 8'd3, 32'd2);
      @(negedge clk);
      check("add_busy_t1", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
      check("add_busy_t2", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
      check("add_busy_t3", {31'd0, req_ready}, 32'd0);
      check("add_wb_we", {31'd0, mem_we}, 32'd1);
      check("add_wb_din", mem_din, 32'd1);
      @(negedge clk);
      check("add_ready_t4", {31'd0, req_ready}, 32'd1);
      @(posedge clk); #1;
      send(OP_READ, 8'd3, 32'd0);
      drain();
`endif

      // randomized mix with random response backpressure
      for (int k = 0; k < 30; k++) begin
         resp_ready = 1'($urandom_range(0, 1));
         send(2'($urandom_range(0, 3)), 8'($urandom_range(32, 39)), $urandom);
      end
      resp_ready = 1'b1;
      drain();

      // reset with reads in flight: nothing comes out, contents survive
      send(OP_WRITE, 8'd20, 32'h1234_5678);
      drain();
      send(OP_READ, 8'd20, 32'd0);
      send(OP_READ, 8'd5, 32'd0);
      rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      check("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
      check("midrst_mem_rst", {31'd0, mem_rst}, 32'd1);
      check("midrst_req_ready", {31'd0, req_ready}, 32'd0);
      check("midrst_mem_en", {31'd0, mem_en}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("post_rst_no_resp", {31'd0, resp_valid}, 32'd0);
      send(OP_READ, 8'd20, 32'd0);
      send(OP_READ, 8'd5, 32'd0);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/reg_rw_ctrl.md
REG_RW_CTRL -- requirements
Module: reg_rw_ctrl

Interface
REQ-001 SHALL have parameter L2_DEPTH, default 8, register-array address width (2**L2_DEPTH entries).
REQ-002 SHALL have parameter WIDTH, default 32, register data width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, response buffer entries (power of two, >=4).
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req_valid/req_ready  input/output  1/1  request handshake; transfer when both high.
REQ-007 req_op  input  2  00 read, 01 write, 10 atomic add (macro-gated), 11 reserved.
REQ-008 req_index  input  L2_DEPTH  register index; req_data  input  WIDTH  write/add operand.
REQ-009 resp_valid/resp_ready  output/input  1/1  response handshake; resp_data  output  WIDTH.
REQ-010 mem_en, mem_we, mem_regce, mem_rst  output  1 each  single-port BRAM port controls.
REQ-011 mem_addr  output  L2_DEPTH; mem_din  output  WIDTH; mem_dout  input  WIDTH  BRAM port, 2-cycle registered read.

Function
REQ-012 Request accepted in cycle T SHALL drive mem_en=1, mem_addr=req_index, mem_we=(op==write), mem_din=req_data in cycle T (combinational from accepted request).
REQ-013 mem_regce SHALL be 1 in cycle T+1 for every issued access; BRAM pipeline never stalls.
REQ-014 mem_dout SHALL be sampled at end of T+2 into response buffer; resp_valid SHALL first be high in T+3.
REQ-015 Every read and write SHALL produce exactly one response, in acceptance order; write response data = written value (write-first).
REQ-016 Op 11 SHALL be accepted, cause no BRAM write (mem_en=0), return response data 0.
REQ-017 req_ready SHALL be high only when (buffer occupancy + in-flight accesses) < FIFO_DEPTH and no atomic add busy; back-to-back requests SHALL sustain one per cycle while resp_ready=1.
REQ-018 resp_valid SHALL remain asserted with stable resp_data until accepted; buffer SHALL never overflow or drop data.
REQ-019 Simultaneous buffer push and pop when full-minus-credit SHALL keep occupancy unchanged.
REQ-020 mem_en=0, mem_we=0 SHALL hold in any cycle with no issue and no add write-back.

Reset
REQ-021 While rst=1: req_ready=0, resp_valid=0, resp_data=0, mem_en=0, mem_we=0, mem_regce=0, mem_rst=1; in-flight accesses, credits and buffer cleared.
REQ-022 Reset mid-operation SHALL discard in-flight responses; no response SHALL appear for requests accepted before reset; BRAM contents unaffected.
REQ-023 req_ready SHALL rise no earlier than first cycle after rst deasserts.

Configuration
REQ-024 With macro REG_RW_ATOMIC_ADD_EN defined, op 10 SHALL read index at T, register (mem_dout + req_data) mod 2**WIDTH at end T+2, write it at T+3 (mem_we=1), respond with the old value; req_ready SHALL be 0 in T+1..T+3.
REQ-025 The T+3 write-back SHALL generate no response; its write-first echo SHALL be discarded.
REQ-026 Without REG_RW_ATOMIC_ADD_EN, op 10 SHALL behave as op 11 and no adder or busy logic SHALL be synthesized.

Structure
REQ-027 Package reg_rw_pkg SHALL hold op encodings (OP_READ, OP_WRITE, OP_ADD, OP_RSVD) and read-latency constant MEM_RD_LAT=2.
REQ-028 Response buffer SHALL be sub-module reg_rw_resp_fifo (synchronous FIFO, registered outputs, occupancy count output).
REQ-029 In-flight tracking SHALL be a MEM_RD_LAT-deep valid/tag shift register inside reg_rw_ctrl.

Verification
REQ-030 Write index 5 data 0xDEADBEEF, then read index 5 -> responses 0xDEADBEEF, 0xDEADBEEF; read resp_valid exactly 3 cycles after acceptance.
REQ-031 Reads of indices 0..7 back-to-back, resp_ready=1 -> 8 in-order responses, req_ready never drops.
REQ-032 resp_ready=0, issue reads continuously -> exactly FIFO_DEPTH (4) accepted, then req_ready=0; releasing resp_ready drains 4 in order.
REQ-033 With REG_RW_ATOMIC_ADD_EN: index 3 = 0xFFFFFFFF, add 2 -> response 0xFFFFFFFF, subsequent read 0x00000001, req_ready low 3 cycles.
REQ-034 Assert rst one cycle after 2 reads accepted -> no responses after reset, resp_valid=0, mem_rst=1 during reset, prior written data intact.
